// File: rtl/rep_add_mul_seq.sv
// rtl/rep_add_mul_seq.sv - self-sequenced repeated-addition multiplier with start/done handshake
// Optional signed operands: define REP_ADD_MUL_SIGNED_EN.
module rep_add_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     count;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   result;
  logic                 accept;
  logic                 finish;

`ifdef REP_ADD_MUL_SIGNED_EN
  logic                 sign;

  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
  always_comb begin
    mag_a  = a_in[WIDTH-1] ? -a_in : a_in;
    mag_b  = b_in[WIDTH-1] ? -b_in : b_in;
    result = sign ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign <= 1'b0;
    end else if (accept) begin
      sign <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
    end
  end
`else
  always_comb begin
    mag_a  = a_in;
    mag_b  = b_in;
    result = acc;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (count == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  // Iterate over the smaller magnitude so latency is min(|a|,|b|)+1
  always_ff @(posedge clk) begin
    if (rst) begin
      addend  <= '0;
      count   <= '0;
      acc     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        if (mag_a >= mag_b) begin
          addend <= mag_a;
          count  <= mag_b;
        end else begin
          addend <= mag_b;
          count  <= mag_a;
        end
        acc <= '0;
      end else if ((state == CALC) && (count != '0)) begin
        acc   <= acc + {{WIDTH{1'b0}}, addend};
        count <= count - WIDTH'(1);
      end
      if (finish) begin
        product <= result;
      end
    end
  end

endmodule

// File: tb/tb_rep_add_mul_seq.sv
// tb/tb_rep_add_mul_seq.sv - table, hand-sequenced and random checks for rep_add_mul_seq
module tb_rep_add_mul_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int compared;
  int mismatched;
  logic [2*W-1:0] last_p;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_p;
    int             exp_lat;
  } vec_t;

  vec_t vecs[$];

  rep_add_mul_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer multiply, latency from the smaller magnitude
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] p, output int lat);
    int sa, sb, ma, mb;
`ifdef REP_ADD_MUL_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    p  = 16'(sa * sb);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    lat = ((ma < mb) ? ma : mb) + 1;
  endtask

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk({tag, " ready timeout"}, 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input int exp_lat, input string tag);
    int lat;
    lat = -1;
    wait_ready(tag);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " product"}, product, exp_p);
    @(posedge clk);
    #1;
    chk({tag, " done pulse width"}, done, 0);
    chk({tag, " back to idle"}, ready, 1);
    last_p = exp_p;
  endtask

  initial begin
    logic [2*W-1:0] p;
    int lat, first_ready, done_cnt;
    logic [W-1:0] ra, rb;

    compared   = 0;
    mismatched = 0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

`ifdef REP_ADD_MUL_SIGNED_EN
    vecs.push_back('{8'hFD, 8'd7,   16'hFFEB, 4});
    vecs.push_back('{8'h80, 8'h80,  16'h4000, 129});
    vecs.push_back('{8'h80, 8'd1,   16'hFF80, 2});
    vecs.push_back('{8'd0,  8'h85,  16'h0000, 1});
    vecs.push_back('{8'd1,  8'd1,   16'h0001, 2});
`else
    vecs.push_back('{8'd200, 8'd3,   16'd600,   4});
    vecs.push_back('{8'd3,   8'd200, 16'd600,   4});
    vecs.push_back('{8'd0,   8'd255, 16'd0,     1});
    vecs.push_back('{8'd255, 8'd255, 16'd65025, 256});
    vecs.push_back('{8'd1,   8'd1,   16'd1,     2});
`endif

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset ready", ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset product", product, 0);
    last_p = '0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // start pulse while busy must be ignored
    wait_ready("busy");
    @(negedge clk);
    a_in = 8'd10; b_in = 8'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("busy product held", product, last_p);
    chk("busy flag", busy, 1);
    a_in = 8'd7; b_in = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 3; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("busy ignore latency", lat, 6);
    chk("busy ignore product", product, 50);
    last_p = 16'd50;

    // start held high: re-accept on the first IDLE cycle
    wait_ready("held");
    @(negedge clk);
    a_in = 8'd10; b_in = 8'd5; start = 1'b1;
    @(posedge clk);
    first_ready = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (ready && first_ready < 0) first_ready = k;
      if (k == 8) chk("held reaccept busy", busy, 1);
    end
    chk("held first idle edge", first_ready, 7);
    start = 1'b0;
    lat = -1;
    for (int k = 13; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("held second done edge", lat, 14);
    chk("held second product", product, 50);

    // reset mid-calculation aborts without a done pulse
    wait_ready("abort");
    @(negedge clk);
    a_in = 8'd100; b_in = 8'd50; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort ready", ready, 1);
    chk("abort busy", busy, 0);
    chk("abort product", product, 0);
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("abort no done", done_cnt, 0);
    last_p = '0;

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (i % 5 == 0) rb = W'($urandom_range(0, 3));
      model(ra, rb, p, lat);
      run_op(ra, rb, p, lat, $sformatf("rand%0d a=%0d b=%0d", i, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
